// File: rtl/id_ex_if.sv
// Decode/execute boundary signals for the ID/EX pipeline register and hazard unit.
// master drives the decode-side fields and the M/W hazard info; slave is the stage itself.
interface id_ex_if;
  logic        RegDstD, ALUSrcD, SignExtD, BranchD, BranchNED, MemtoRegD, MemWriteD, RegWriteD;
  logic [3:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ExtImmD, PCPlus4D;
  logic [4:0]  RsD, RtD, RdD;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, RegWriteW;
  logic        PCSrcE;

  logic        RegDstE, ALUSrcE, SignExtE, BranchE, BranchNE, MemtoRegE, MemWriteE, RegWriteE, ValidE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ExtImmE, PCPlus4E;
  logic [4:0]  RsE, RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD;
  logic [15:0] StallCount;

  modport master (
    output RegDstD, ALUSrcD, SignExtD, BranchD, BranchNED, MemtoRegD, MemWriteD, RegWriteD,
    output ALUControlD, RD1D, RD2D, ExtImmD, PCPlus4D, RsD, RtD, RdD,
    output WriteRegM, WriteRegW, RegWriteM, RegWriteW, PCSrcE,
    input  RegDstE, ALUSrcE, SignExtE, BranchE, BranchNE, MemtoRegE, MemWriteE, RegWriteE, ValidE,
    input  ALUControlE, RD1E, RD2E, ExtImmE, PCPlus4E, RsE, RtE, RdE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, StallCount
  );

  modport slave (
    input  RegDstD, ALUSrcD, SignExtD, BranchD, BranchNED, MemtoRegD, MemWriteD, RegWriteD,
    input  ALUControlD, RD1D, RD2D, ExtImmD, PCPlus4D, RsD, RtD, RdD,
    input  WriteRegM, WriteRegW, RegWriteM, RegWriteW, PCSrcE,
    output RegDstE, ALUSrcE, SignExtE, BranchE, BranchNE, MemtoRegE, MemWriteE, RegWriteE, ValidE,
    output ALUControlE, RD1E, RD2E, ExtImmE, PCPlus4E, RsE, RtE, RdE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, StallCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, E-stage forwarding selects
// and a saturating load-use stall counter.
module id_ex_stage (
  input  logic    clk,
  input  logic    rst_n,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic        reg_dst;
    logic        alu_src;
    logic        sign_ext;
    logic        branch;
    logic        branch_ne;
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext_imm;
    logic [31:0] pc_plus4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;

  ex_t         r_ex;
  ex_t         w_ex_d;
  logic [15:0] r_stall_count;
  logic        w_load_use;
  logic        w_stall;
  logic        w_flush_e;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_m, input logic [4:0] reg_m,
                                         input logic       wr_w, input logic [4:0] reg_w);
    if (wr_m && (reg_m != 5'd0) && (reg_m == src))
      return 2'b10;
    else if (wr_w && (reg_w != 5'd0) && (reg_w == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_ex_d = '{
    reg_dst:    bus.RegDstD,
    alu_src:    bus.ALUSrcD,
    sign_ext:   bus.SignExtD,
    branch:     bus.BranchD,
    branch_ne:  bus.BranchNED,
    mem_to_reg: bus.MemtoRegD,
    mem_write:  bus.MemWriteD,
    reg_write:  bus.RegWriteD,
    valid:      1'b1,
    alu_ctrl:   bus.ALUControlD,
    rd1:        bus.RD1D,
    rd2:        bus.RD2D,
    ext_imm:    bus.ExtImmD,
    pc_plus4:   bus.PCPlus4D,
    rs:         bus.RsD,
    rt:         bus.RtD,
    rd:         bus.RdD
  };

  assign w_load_use = r_ex.mem_to_reg && r_ex.valid && (r_ex.rt != 5'd0) &&
                      ((r_ex.rt == bus.RsD) || (r_ex.rt == bus.RtD));
  // A taken branch kills the stalled instruction anyway, so it suppresses the stall.
  assign w_stall    = w_load_use && !bus.PCSrcE;
  assign w_flush_e  = bus.PCSrcE || w_load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex          <= '0;
      r_stall_count <= '0;
    end else begin
      r_ex <= w_flush_e ? '0 : w_ex_d;
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.StallF      = w_stall;
  assign bus.StallD      = w_stall;
  assign bus.FlushD      = bus.PCSrcE;
  assign bus.StallCount  = r_stall_count;

  assign bus.ForwardAE   = fwd_sel(r_ex.rs, bus.RegWriteM, bus.WriteRegM, bus.RegWriteW, bus.WriteRegW);
  assign bus.ForwardBE   = fwd_sel(r_ex.rt, bus.RegWriteM, bus.WriteRegM, bus.RegWriteW, bus.WriteRegW);

  assign bus.RegDstE     = r_ex.reg_dst;
  assign bus.ALUSrcE     = r_ex.alu_src;
  assign bus.SignExtE    = r_ex.sign_ext;
  assign bus.BranchE     = r_ex.branch;
  assign bus.BranchNE    = r_ex.branch_ne;
  assign bus.MemtoRegE   = r_ex.mem_to_reg;
  assign bus.MemWriteE   = r_ex.mem_write;
  assign bus.RegWriteE   = r_ex.reg_write;
  assign bus.ValidE      = r_ex.valid;
  assign bus.ALUControlE = r_ex.alu_ctrl;
  assign bus.RD1E        = r_ex.rd1;
  assign bus.RD2E        = r_ex.rd2;
  assign bus.ExtImmE     = r_ex.ext_imm;
  assign bus.PCPlus4E    = r_ex.pc_plus4;
  assign bus.RsE         = r_ex.rs;
  assign bus.RtE         = r_ex.rt;
  assign bus.RdE         = r_ex.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, branch flush,
// forwarding priority, reset and stall-counter saturation.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d();
    bus.RegDstD = 0; bus.ALUSrcD = 0; bus.SignExtD = 0; bus.BranchD = 0; bus.BranchNED = 0;
    bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.RegWriteD = 0;
    bus.ALUControlD = 4'h0;
    bus.RD1D = 32'h0; bus.RD2D = 32'h0; bus.ExtImmD = 32'h0; bus.PCPlus4D = 32'h0;
    bus.RsD = 5'd0; bus.RtD = 5'd0; bus.RdD = 5'd0;
  endtask

  // Put a load writing rt into E; D is left holding a non-dependent instruction.
  task automatic load_lw(input logic [4:0] rt);
    clr_d();
    bus.MemtoRegD = 1; bus.RegWriteD = 1; bus.RtD = rt; bus.RsD = 5'd1;
    step();
    clr_d();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    clr_d();
    bus.WriteRegM = 5'd0; bus.WriteRegW = 5'd0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.PCSrcE = 0;

    // Reset with live D inputs
    bus.RD1D = 32'hDEAD_BEEF; bus.RegWriteD = 1; bus.RsD = 5'd4; bus.ALUControlD = 4'hA;
    step(); step();
    chk("rst_valid",   bus.ValidE,      0);
    chk("rst_rd1",     bus.RD1E,        0);
    chk("rst_regwr",   bus.RegWriteE,   0);
    chk("rst_alu",     bus.ALUControlE, 0);
    chk("rst_cnt",     bus.StallCount,  0);
    chk("rst_stalld",  bus.StallD,      0);
    chk("rst_fwda",    bus.ForwardAE,   0);

    // Pass-through
    rst_n = 1'b1;
    clr_d();
    bus.RD1D = 32'h1234_5678; bus.RsD = 5'd3; bus.RegWriteD = 1;
    bus.ALUControlD = 4'h6; bus.PCPlus4D = 32'h0000_0104; bus.RdD = 5'd12; bus.ALUSrcD = 1;
    step();
    chk("pt_rd1",      bus.RD1E,        32'h1234_5678);
    chk("pt_rs",       bus.RsE,         3);
    chk("pt_regwr",    bus.RegWriteE,   1);
    chk("pt_valid",    bus.ValidE,      1);
    chk("pt_alu",      bus.ALUControlE, 4'h6);
    chk("pt_pc4",      bus.PCPlus4E,    32'h0000_0104);
    chk("pt_rd",       bus.RdE,         12);
    chk("pt_alusrc",   bus.ALUSrcE,     1);

    // Forward priority with RsE=RtE=7
    clr_d();
    bus.RsD = 5'd7; bus.RtD = 5'd7;
    step();
    clr_d();
    bus.RegWriteM = 1; bus.WriteRegM = 5'd7; bus.RegWriteW = 1; bus.WriteRegW = 5'd7;
    #1;
    chk("fwd_mw_a",    bus.ForwardAE,   2'b10);
    chk("fwd_mw_b",    bus.ForwardBE,   2'b10);
    bus.RegWriteM = 0;
    #1;
    chk("fwd_w_a",     bus.ForwardAE,   2'b01);
    chk("fwd_w_b",     bus.ForwardBE,   2'b01);
    bus.WriteRegW = 5'd0;
    #1;
    chk("fwd_none_a",  bus.ForwardAE,   2'b00);
    chk("fwd_none_b",  bus.ForwardBE,   2'b00);

    // Mixed: A from M, B from W
    bus.RsD = 5'd7; bus.RtD = 5'd9;
    step();
    clr_d();
    bus.RegWriteM = 1; bus.WriteRegM = 5'd7; bus.RegWriteW = 1; bus.WriteRegW = 5'd9;
    #1;
    chk("fwd_mix_a",   bus.ForwardAE,   2'b10);
    chk("fwd_mix_b",   bus.ForwardBE,   2'b01);

    // Register 0 never forwards
    bus.RsD = 5'd0; bus.RtD = 5'd0;
    step();
    bus.RegWriteM = 1; bus.WriteRegM = 5'd0; bus.RegWriteW = 1; bus.WriteRegW = 5'd0;
    #1;
    chk("fwd_r0_a",    bus.ForwardAE,   2'b00);
    chk("fwd_r0_b",    bus.ForwardBE,   2'b00);
    bus.RegWriteM = 0; bus.RegWriteW = 0;

    // Load-use stall
    load_lw(5'd5);
    chk("lu_lw_mtr",   bus.MemtoRegE,   1);
    bus.RsD = 5'd5;
    #1;
    chk("lu_stallf",   bus.StallF,      1);
    chk("lu_stalld",   bus.StallD,      1);
    chk("lu_flushd",   bus.FlushD,      0);
    step();
    chk("lu_bubble",   bus.ValidE,      0);
    chk("lu_bub_rw",   bus.RegWriteE,   0);
    chk("lu_bub_rs",   bus.RsE,         0);
    chk("lu_cnt",      bus.StallCount,  1);
    chk("lu_release",  bus.StallD,      0);

    // Load-use via RtD
    load_lw(5'd6);
    bus.RtD = 5'd6;
    #1;
    chk("lu_rt_stall", bus.StallD,      1);
    step();
    chk("lu_rt_cnt",   bus.StallCount,  2);

    // Load into r0 never stalls
    load_lw(5'd0);
    bus.RsD = 5'd0;
    #1;
    chk("lu_r0",       bus.StallD,      0);
    step();
    chk("lu_r0_cnt",   bus.StallCount,  2);

    // Branch taken in the same cycle as a load-use hazard
    load_lw(5'd5);
    bus.RsD = 5'd5; bus.PCSrcE = 1;
    #1;
    chk("br_flushd",   bus.FlushD,      1);
    chk("br_stallf",   bus.StallF,      0);
    chk("br_stalld",   bus.StallD,      0);
    step();
    chk("br_bubble",   bus.ValidE,      0);
    chk("br_cnt",      bus.StallCount,  2);
    bus.PCSrcE = 0;

    // Branch flush on an ordinary instruction
    clr_d();
    bus.RegWriteD = 1; bus.RdD = 5'd3; bus.PCSrcE = 1;
    step();
    chk("br_plain",    bus.RegWriteE,   0);
    bus.PCSrcE = 0;

    // Build StallCount up to 10 then reset mid-stall with live D inputs
    for (int i = 0; i < 8; i++) begin
      load_lw(5'd5);
      bus.RsD = 5'd5;
      step();
    end
    chk("cnt10",       bus.StallCount,  10);
    load_lw(5'd5);
    bus.RsD = 5'd5; bus.RD1D = 32'hCAFE_F00D; bus.RegWriteD = 1;
    #1;
    chk("rs_pre",      bus.StallD,      1);
    rst_n = 1'b0;
    step();
    chk("rs_cnt",      bus.StallCount,  0);
    chk("rs_valid",    bus.ValidE,      0);
    chk("rs_rd1",      bus.RD1E,        0);
    chk("rs_mtr",      bus.MemtoRegE,   0);
    chk("rs_stalld",   bus.StallD,      0);
    chk("rs_fwda",     bus.ForwardAE,   0);
    chk("rs_fwdb",     bus.ForwardBE,   0);
    rst_n = 1'b1;
    clr_d();

    // Saturation: hold the load-use condition for more than 65535 edges
    force dut.w_load_use = 1'b1;
    #1;
    chk("sat_stall",   bus.StallD,      1);
    repeat (65534) step();
    chk("sat_fffe",    bus.StallCount,  16'hFFFE);
    step();
    chk("sat_ffff",    bus.StallCount,  16'hFFFF);
    repeat (3) step();
    chk("sat_hold",    bus.StallCount,  16'hFFFF);
    release dut.w_load_use;
    step();
    chk("sat_after",   bus.StallCount,  16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock, clk, with all state updating on its rising edge; reset is rst_n, synchronous, active-low.
REQ-002 Port clk  input  1  sole clock.
REQ-003 Port rst_n  input  1  synchronous active-low reset.
REQ-004 Ports RegDstD, ALUSrcD, SignExtD, BranchD, BranchNED, MemtoRegD, MemWriteD, RegWriteD  input  1 each  decoded controls from decode.
REQ-005 Port ALUControlD  input  4  decoded ALU operation.
REQ-006 Ports RD1D, RD2D, ExtImmD, PCPlus4D  input  32 each  decode-stage operands.
REQ-007 Ports RsD, RtD, RdD  input  5 each  decode-stage register specifiers.
REQ-008 Ports WriteRegM, WriteRegW  input  5  destination registers in M and W; RegWriteM, RegWriteW  input  1  their write enables.
REQ-009 Port PCSrcE  input  1  branch-taken from execute.
REQ-010 Ports RegDstE, ALUSrcE, SignExtE, BranchE, BranchNE, MemtoRegE, MemWriteE, RegWriteE, ValidE  output  1  registered execute-stage controls.
REQ-011 Ports ALUControlE  output  4; RD1E, RD2E, ExtImmE, PCPlus4E  output  32; RsE, RtE, RdE  output  5  registered execute-stage fields.
REQ-012 Ports ForwardAE, ForwardBE  output  2  forwarding selects (00 register file, 01 ResultW, 10 ALUOutM).
REQ-013 Ports StallF, StallD, FlushD  output  1  pipeline hazard controls.
REQ-014 Port StallCount  output  16  count of load-use stall cycles.

Function
REQ-015 LoadUse SHALL be MemtoRegE & ValidE & RtE!=0 & (RtE==RsD | RtE==RtD).
REQ-016 StallF and StallD SHALL equal LoadUse & !PCSrcE, combinationally.
REQ-017 FlushD SHALL equal PCSrcE, combinationally.
REQ-018 FlushE (internal) SHALL equal PCSrcE | LoadUse.
REQ-019 On a clock edge with FlushE=1, all E control outputs (incl. ValidE, RegWriteE, MemWriteE, MemtoRegE, BranchE, BranchNE) SHALL load 0, ALUControlE 0, and data/specifier fields 0 (bubble).
REQ-020 On a clock edge with FlushE=0, every E output SHALL load its D counterpart, ValidE SHALL load 1; latency D to E exactly one cycle.
REQ-021 PCSrcE and LoadUse both 1: flush wins; bubble inserted, StallF/StallD=0.
REQ-022 ForwardAE SHALL be 10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW!=0 & WriteRegW==RsE; else 00; combinational from E state.
REQ-023 ForwardBE SHALL follow REQ-022 with RtE in place of RsE.
REQ-024 M match SHALL take priority over W match; code 11 SHALL never be produced.
REQ-025 Register 0 SHALL never forward nor cause a load-use stall.
REQ-026 StallCount SHALL increment by 1 on each edge where StallD=1, saturate at 16'hFFFF, never wrap.

Reset
REQ-027 On an edge with rst_n=0, all E outputs and StallCount SHALL become 0; reset overrides flush and load.
REQ-028 During and after reset until first valid load, ForwardAE/ForwardBE=00 and StallF/StallD=0 (since E state is zero).
REQ-029 Reset asserted mid-stall SHALL clear the bubble state and StallCount in the same edge; StallD returns 0 next cycle.

Verification
REQ-030 Pass-through: rst_n=1, RD1D=32'h1234_5678, RsD=3, RegWriteD=1 -> next cycle RD1E=32'h1234_5678, RsE=3, RegWriteE=1, ValidE=1.
REQ-031 Load-use: E holds lw with RtE=5, MemtoRegE=1; D has RsD=5 -> StallF=StallD=1, next edge E is bubble (ValidE=0), StallCount 0->1; following cycle StallD=0.
REQ-032 Forward priority: RsE=RtE=7, RegWriteM=1 WriteRegM=7, RegWriteW=1 WriteRegW=7 -> ForwardAE=ForwardBE=10; clear RegWriteM -> both 01; WriteRegW=0 -> both 00.
REQ-033 Branch vs stall: LoadUse condition and PCSrcE=1 same cycle -> FlushD=1, StallF=StallD=0, next edge E bubble, StallCount unchanged.
REQ-034 Saturation: force 65536 consecutive stall cycles -> StallCount holds 16'hFFFF.
REQ-035 Reset: rst_n=0 for one edge with live D inputs and StallCount=10 -> all E outputs 0, StallCount 0, ForwardAE/BE=00.
